// File: rtl/axi_burst_addr_gen_pkg.sv
// Shared AXI burst/size encodings, page constant and FSM state type for the
// burst address generator.
package axi_burst_addr_gen_pkg;

  // AXI bursts never cross a 4KB page; the page offset is 12 bits wide.
  localparam int unsigned PageW = 12;

  typedef enum logic [1:0] {
    BurstFixed = 2'b00,
    BurstIncr  = 2'b01,
    BurstWrap  = 2'b10,
    BurstRsvd  = 2'b11
  } axi_burst_e;

  typedef enum logic [2:0] {
    Size1B   = 3'd0,
    Size2B   = 3'd1,
    Size4B   = 3'd2,
    Size8B   = 3'd3,
    Size16B  = 3'd4,
    Size32B  = 3'd5,
    Size64B  = 3'd6,
    Size128B = 3'd7
  } axi_size_e;

  typedef enum logic {
    StIdle,
    StBurst
  } gen_state_e;

  // WRAP bursts are only defined for 2, 4, 8 or 16 beats.
  function automatic logic wrap_len_ok(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

endpackage

// File: rtl/axi_beat_addr_calc.sv
// Combinational next-beat address for FIXED, INCR and WRAP bursts.
module axi_beat_addr_calc
  import axi_burst_addr_gen_pkg::*;
#(
  parameter int unsigned ADDR_W = 20
) (
  input  logic [ADDR_W-1:0] cur_addr_i,
  input  logic [2:0]        size_i,
  input  logic [7:0]        len_i,
  input  axi_burst_e        burst_i,
  input  logic [ADDR_W-1:0] wrap_base_i,
  output logic [ADDR_W-1:0] next_addr_o
);

  logic [ADDR_W-1:0] step;
  logic [ADDR_W-1:0] aligned;
  logic [ADDR_W-1:0] sum;
  logic [ADDR_W-1:0] wrap_bytes;
  logic [ADDR_W-1:0] page_mask;

  always_comb begin
    step       = ADDR_W'(1) << size_i;
    aligned    = cur_addr_i & ~(step - ADDR_W'(1));
    sum        = aligned + step;
    wrap_bytes = (ADDR_W'(len_i) + ADDR_W'(1)) << size_i;
    // Upper bits frozen at the page; mask is zero when ADDR_W equals the page width.
    page_mask  = ~((ADDR_W'(1) << PageW) - ADDR_W'(1));

    next_addr_o = cur_addr_i;
    unique case (burst_i)
      BurstIncr: next_addr_o = (cur_addr_i & page_mask) | (sum & ~page_mask);
      BurstWrap: next_addr_o = (sum == wrap_base_i + wrap_bytes) ? wrap_base_i : sum;
      default:   next_addr_o = cur_addr_i;
    endcase
  end

endmodule

// File: rtl/axi_burst_addr_gen.sv
// AXI burst address generator: accepts one AxADDR-style command and issues one
// registered address beat per handshake, with back-to-back command acceptance.
module axi_burst_addr_gen
  import axi_burst_addr_gen_pkg::*;
#(
  parameter int unsigned ADDR_W   = 20,
  parameter int unsigned MAX_SIZE = 3
) (
  input  logic              aclk_i,
  input  logic              areset_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [ADDR_W-1:0] cmd_addr_i,
  input  logic [7:0]        cmd_len_i,
  input  logic [2:0]        cmd_size_i,
  input  logic [1:0]        cmd_burst_i,
  output logic              beat_valid_o,
  input  logic              beat_ready_i,
  output logic [ADDR_W-1:0] beat_addr_o,
  output logic              beat_last_o,
  output logic [7:0]        beat_idx_o,
  output logic              beat_err_o
);

  gen_state_e        state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] base_q;
  logic [7:0]        idx_q;
  logic [7:0]        len_q;
  logic [2:0]        size_q;
  axi_burst_e        burst_q;
  logic              valid_q;
  logic              last_q;
  logic              err_q;

  axi_burst_e        cmd_burst;
  logic [ADDR_W-1:0] cmd_step;
  logic [ADDR_W-1:0] cmd_wrap_bytes;
  logic [ADDR_W-1:0] cmd_base;
  logic              cmd_err;
  logic              cmd_fire;
  logic              beat_fire;
  logic [ADDR_W-1:0] next_addr;

  always_comb begin
    cmd_burst      = axi_burst_e'(cmd_burst_i);
    cmd_step       = ADDR_W'(1) << cmd_size_i;
    cmd_wrap_bytes = (ADDR_W'(cmd_len_i) + ADDR_W'(1)) << cmd_size_i;
    cmd_base       = cmd_addr_i & ~(cmd_wrap_bytes - ADDR_W'(1));
    cmd_err        = (cmd_burst == BurstRsvd) ||
                     (32'(cmd_size_i) > MAX_SIZE) ||
                     ((cmd_burst == BurstWrap) &&
                      (!wrap_len_ok(cmd_len_i) ||
                       ((cmd_addr_i & (cmd_step - ADDR_W'(1))) != '0)));
  end

  // Ready in the last-beat handshake cycle lets the next burst start with no bubble.
  assign cmd_ready_o = (state_q == StIdle) || (valid_q && beat_ready_i && last_q);
  assign cmd_fire    = cmd_valid_i && cmd_ready_o;
  assign beat_fire   = valid_q && beat_ready_i;

  axi_beat_addr_calc #(
    .ADDR_W(ADDR_W)
  ) u_calc (
    .cur_addr_i (addr_q),
    .size_i     (size_q),
    .len_i      (len_q),
    .burst_i    (burst_q),
    .wrap_base_i(base_q),
    .next_addr_o(next_addr)
  );

  always_ff @(posedge aclk_i) begin
    if (areset_i) begin
      state_q <= StIdle;
      addr_q  <= '0;
      base_q  <= '0;
      idx_q   <= '0;
      len_q   <= '0;
      size_q  <= '0;
      burst_q <= BurstFixed;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
    end else if (cmd_fire) begin
      state_q <= StBurst;
      addr_q  <= cmd_addr_i;
      base_q  <= cmd_base;
      idx_q   <= '0;
      len_q   <= cmd_len_i;
      size_q  <= cmd_size_i;
      // Illegal commands replay the start address, exactly like FIXED.
      burst_q <= cmd_err ? BurstFixed : cmd_burst;
      valid_q <= 1'b1;
      last_q  <= (cmd_len_i == 8'd0);
      err_q   <= cmd_err;
    end else if (beat_fire) begin
      if (last_q) begin
        state_q <= StIdle;
        valid_q <= 1'b0;
        last_q  <= 1'b0;
        err_q   <= 1'b0;
      end else begin
        addr_q <= next_addr;
        idx_q  <= idx_q + 8'd1;
        last_q <= ((idx_q + 8'd1) == len_q);
      end
    end
  end

  assign beat_valid_o = valid_q;
  assign beat_addr_o  = addr_q;
  assign beat_last_o  = last_q;
  assign beat_idx_o   = idx_q;
  assign beat_err_o   = err_q;

endmodule

// File: doc/axi_burst_addr_gen.md
AXI_BURST_ADDR_GEN -- requirements
Module: axi_burst_addr_gen

Interface
REQ-001 Parameter ADDR_W, default 20, address width in bits (12..64).
REQ-002 Parameter MAX_SIZE, default 3, largest legal AxSIZE (log2 of data-bus bytes, 0..7).
REQ-003 ACLK  input  1  clock; all state changes on rising edge.
REQ-004 ARESET  input  1  reset; synchronous and active-high.
REQ-005 CmdValid / CmdReady  input / output  1 / 1  command handshake.
REQ-006 CmdAddr / CmdLen / CmdSize / CmdBurst  input  ADDR_W / 8 / 3 / 2  AxADDR, AxLEN, AxSIZE, AxBURST.
REQ-007 BeatValid / BeatReady  output / input  1 / 1  per-beat address handshake.
REQ-008 BeatAddr  output  ADDR_W  address of current beat.
REQ-009 BeatLast  output  1  current beat is final beat of burst.
REQ-010 BeatIdx  output  8  beat number within burst, 0-based.
REQ-011 BeatErr  output  1  command was illegal; downstream returns SLVERR for this beat.

Function
REQ-012 States IDLE and BURST; command transfers when CmdValid and CmdReady are both high on a rising edge.
REQ-013 CmdReady high in IDLE, and high in BURST only in a cycle where BeatValid, BeatReady and BeatLast are all high (zero-bubble back-to-back).
REQ-014 Accepted command: BURST entered next cycle, BeatValid=1, BeatAddr=CmdAddr, BeatIdx=0; all outputs registered; latency exactly 1 cycle.
REQ-015 BeatValid held high and BeatAddr/BeatIdx/BeatLast/BeatErr stable until BeatReady; beat advances only on BeatValid&BeatReady.
REQ-016 BeatLast=1 iff BeatIdx==captured CmdLen; handshake on last beat returns to IDLE (BeatValid=0) unless a new command is accepted in same cycle.
REQ-017 FIXED (00): every beat address = CmdAddr.
REQ-018 INCR (01): next = (current aligned down to 2^Size) + 2^Size; first beat keeps unaligned start address.
REQ-019 INCR: bits [ADDR_W-1:12] held at start value; a carry out of bit 11 wraps within the 4KB page.
REQ-020 WRAP (10): boundary = CmdAddr aligned down to (CmdLen+1)<<CmdSize; address reaching boundary+((CmdLen+1)<<CmdSize) returns to boundary.
REQ-021 Illegal command: CmdBurst=11, CmdSize>MAX_SIZE, WRAP with CmdLen not in {1,3,7,15}, or WRAP with CmdAddr not aligned to 2^CmdSize.
REQ-022 Illegal command still accepted and issues CmdLen+1 beats, every beat BeatAddr=CmdAddr and BeatErr=1; legal commands give BeatErr=0.
REQ-023 Arithmetic in ADDR_W bits; increment is 2^CmdSize; no overflow beyond the 4KB page rule.
REQ-024 CmdLen 0..255 for INCR/FIXED; CmdLen=0 gives one beat with BeatLast=1.

Reset
REQ-025 ARESET high at a rising edge: state IDLE, BeatValid=0, BeatLast=0, BeatErr=0, BeatIdx=0, BeatAddr=0, CmdReady=1 from next cycle.
REQ-026 Reset mid-burst abandons remaining beats; no beat completes in the reset cycle.
REQ-027 ARESET overrides a same-edge command handshake; that command is dropped.

Structure
REQ-028 Shared package holds AxBURST encodings (FIXED/INCR/WRAP), AxSIZE encodings and 4KB page width constant (12).
REQ-029 Single sub-module axi_beat_addr_calc (combinational next-address from current address, size, len, burst, boundary); FSM, counter and registers in top.

Verification
REQ-030 INCR, Addr=0x00104, Len=3, Size=2, BeatReady=1 -> beats 0x00104,0x00108,0x0010C,0x00110; BeatLast on 4th; BeatValid 1 cycle after accept.
REQ-031 WRAP, Addr=0x0003C, Len=3, Size=2 -> 0x0003C,0x00030,0x00034,0x00038; BeatErr=0.
REQ-032 INCR, Addr=0x00FFE, Len=2, Size=1, BeatReady toggling -> 0x00FFE,0x00000,0x00002 each held until ready; page bits [19:12] unchanged.
REQ-033 Two queued commands (FIXED Addr=0x00200 Len=1; INCR Addr=0x00003 Len=1 Size=2) -> 0x00200,0x00200,0x00003,0x00004 with no idle cycle between bursts.
REQ-034 WRAP Len=2 Addr=0x00040 -> 3 beats at 0x00040, all BeatErr=1; CmdSize=4 with MAX_SIZE=3 -> same error behaviour.
REQ-035 ARESET asserted at beat 2 of INCR Len=7 -> next cycle BeatValid=0, BeatIdx=0, CmdReady=1; following command starts at its own CmdAddr.
